// File: rtl/d_sram_bridge_pkg.sv
// Shared types and constants for the data-side SRAM-like bridge.
// Address-map constants are used only when DBRIDGE_ADDR_MAP_EN is defined.
package d_sram_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2
  } bridgeState_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) share top bits 2'b10; mapping clears the top three bits
  localparam logic [1:0] KSEG01_TAG   = 2'b10;
  localparam int         KSEG_STRIP_W = 3;

endpackage

// File: rtl/d_addr_map.sv
// Virtual-to-physical address mapping for data accesses.
// With DBRIDGE_ADDR_MAP_EN defined, kseg0/kseg1 fold onto the low 512 MB; otherwise pass-through.
module d_addr_map
  import d_sram_bridge_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] vaddr,
  output logic [AW-1:0] paddr
);

`ifdef DBRIDGE_ADDR_MAP_EN
  always_comb begin
    paddr = vaddr;
    if (vaddr[AW-1 -: 2] == KSEG01_TAG) begin
      paddr = {{KSEG_STRIP_W{1'b0}}, vaddr[AW-KSEG_STRIP_W-1:0]};
    end
  end
`else
  assign paddr = vaddr;
`endif

endmodule

// File: rtl/d_sram_bridge.sv
// Bridges the MIPS M-stage data access onto an SRAM-like req/addr_ok/data_ok port.
// Optional macro DBRIDGE_ADDR_MAP_EN enables kseg0/kseg1 address folding in d_addr_map.
module d_sram_bridge
  import d_sram_bridge_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memreadM,
  input  logic          memwriteM,
  input  logic [AW-1:0] aluoutM,
  input  logic [DW-1:0] writedataM,
  input  logic [3:0]    selectM,
  input  logic          flushM,
  input  logic          longest_stall,
  output logic [DW-1:0] readdataM,
  output logic          d_stall,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata
);

  bridgeState_e  state;
  bridgeState_e  stateNext;
  logic [DW-1:0] rdataR;
  logic          access;
  logic          dataDone;

  function automatic logic [1:0] sizeDecode(input logic [3:0] sel);
    case (sel)
      4'b1111:                            sizeDecode = SIZE_W;
      4'b0011, 4'b1100:                   sizeDecode = SIZE_H;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sizeDecode = SIZE_B;
      default:                            sizeDecode = SIZE_W;
    endcase
  endfunction

  function automatic logic selLegal(input logic [3:0] sel);
    selLegal = (sel == 4'b1111) || (sel == 4'b0011) || (sel == 4'b1100) || $onehot(sel);
  endfunction

  assign access   = (memreadM | memwriteM) & ~flushM;
  assign dataDone = (state == S_DATA) & data_data_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Load data is kept until the stalled pipeline finally consumes it
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdataR <= '0;
    end else if (dataDone && memreadM) begin
      rdataR <= data_rdata;
    end
  end

  always_comb begin
    stateNext = state;
    data_req  = 1'b0;
    case (state)
      S_IDLE: begin
        data_req = access;
        if (access && data_addr_ok) begin
          stateNext = S_DATA;
        end
      end
      S_DATA: begin
        // flushM is ignored here: an accepted request must see its data_ok
        if (data_data_ok) begin
          stateNext = longest_stall ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        if (!longest_stall) begin
          stateNext = S_IDLE;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  assign readdataM  = dataDone ? data_rdata : rdataR;
  assign d_stall    = access & ~dataDone & (state != S_DONE);
  assign data_wr    = memwriteM;
  assign data_wdata = writedataM;
  assign data_size  = sizeDecode(selectM);

  d_addr_map #(
    .AW(AW)
  ) uAddrMap (
    .vaddr(aluoutM),
    .paddr(data_addr)
  );

  assert property (@(posedge clk) disable iff (!rst) access |-> selLegal(selectM))
    else $error("illegal selectM byte-enable pattern");

  assert property (@(posedge clk) disable iff (!rst)
                   !((state == S_IDLE) && data_addr_ok && data_data_ok))
    else $error("addr_ok and data_ok together while idle");

endmodule

// File: tb/tb_d_sram_bridge.sv
// Scoreboard bench for d_sram_bridge: random M-stage accesses against a behavioural
// SRAM-like slave; expected requests and load data are queued and checked by a monitor.
module tb_d_sram_bridge;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          memreadM, memwriteM, flushM, extStall, longestStall;
  logic [AW-1:0] aluoutM;
  logic [DW-1:0] writedataM;
  logic [3:0]    selectM;
  logic [DW-1:0] readdataM;
  logic          dStall, dataReq, dataWr;
  logic [1:0]    dataSize;
  logic [AW-1:0] dataAddr;
  logic [DW-1:0] dataWdata;
  logic          dataAddrOk, dataDataOk;
  logic [DW-1:0] dataRdata;

  always #5 clk = ~clk;
  assign longestStall = dStall | extStall;

  d_sram_bridge #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .memreadM(memreadM), .memwriteM(memwriteM), .aluoutM(aluoutM),
    .writedataM(writedataM), .selectM(selectM), .flushM(flushM),
    .longest_stall(longestStall), .readdataM(readdataM), .d_stall(dStall),
    .data_req(dataReq), .data_wr(dataWr), .data_size(dataSize),
    .data_addr(dataAddr), .data_wdata(dataWdata),
    .data_addr_ok(dataAddrOk), .data_data_ok(dataDataOk), .data_rdata(dataRdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } req_t;

  int          checks = 0;
  int          errors = 0;
  req_t        reqQ[$];
  logic [31:0] loadQ[$];
  logic [31:0] modelMem [int unsigned];
  logic [31:0] slaveMem [int unsigned];
  int          aWaitCfg = 0;
  int          dWaitCfg = 0;
  logic [31:0] lastLoad = 32'h0;
  bit          curIsLoad = 1'b0;
  req_t        monReq;
  logic [3:0]  selTab [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [31:0] regionTab [4] = '{32'h8000_0000, 32'hA000_0000, 32'h0000_0000, 32'hC000_0000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mapAddr(input logic [31:0] va);
`ifdef DBRIDGE_ADDR_MAP_EN
    if (va >= 32'h8000_0000 && va <= 32'hBFFF_FFFF) return va & 32'h1FFF_FFFF;
`endif
    return va;
  endfunction

  function automatic logic [1:0] expSize(input logic [3:0] sel);
    if (sel == 4'hF) return 2'd2;
    if ($countones(sel) == 1) return 2'd0;
    return 2'd1;
  endfunction

  function automatic logic [1:0] laneOf(input logic [3:0] sel);
    for (int b = 0; b < 4; b++) if (sel[b]) return 2'(b);
    return 2'd0;
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] pa, input bit fromSlave);
    int unsigned k = pa >> 2;
    if (fromSlave) return slaveMem.exists(k) ? slaveMem[k] : 32'h0;
    return modelMem.exists(k) ? modelMem[k] : 32'h0;
  endfunction

  // Slave honours only size + address, so lane selection is re-derived independently of selectM
  task automatic slaveWrite(input logic [31:0] pa, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w = memRead(pa, 1'b1);
    for (int b = 0; b < 4; b++) begin
      bit en;
      case (sz)
        2'd0:    en = (b == int'(pa[1:0]));
        2'd1:    en = ((b / 2) == int'(pa[1]));
        default: en = 1'b1;
      endcase
      if (en) w[8*b +: 8] = wd[8*b +: 8];
    end
    slaveMem[pa >> 2] = w;
  endtask

  // Behavioural SRAM-like slave with programmable addr_ok / data_ok delays
  initial begin : slave
    bit          pending = 1'b0;
    int          aCnt = 0;
    int          dCnt = 0;
    logic [31:0] pAddr = 32'h0;
    bit          pWr = 1'b0;
    dataAddrOk = 1'b0;
    dataDataOk = 1'b0;
    dataRdata  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      dataAddrOk = 1'b0;
      dataDataOk = 1'b0;
      dataRdata  = $urandom;
      if (!rst) begin
        pending = 1'b0;
        aCnt = 0;
        dCnt = 0;
      end else if (pending) begin
        if (dCnt == dWaitCfg) begin
          dataDataOk = 1'b1;
          if (!pWr) dataRdata = memRead(pAddr, 1'b1);
          pending = 1'b0;
        end else begin
          dCnt++;
        end
      end else if (dataReq) begin
        if (aCnt == aWaitCfg) begin
          dataAddrOk = 1'b1;
          pending = 1'b1;
          aCnt = 0;
          dCnt = 0;
          pAddr = dataAddr;
          pWr = dataWr;
          if (dataWr) slaveWrite(dataAddr, dataSize, dataWdata);
        end else begin
          aCnt++;
        end
      end else begin
        aCnt = 0;
      end
    end
  end

  // Monitor: request fields at acceptance, load data and stall release at data_ok
  always @(negedge clk) begin
    if (rst) begin
      if (dataReq && dataAddrOk) begin
        if (reqQ.size() == 0) begin
          chk("unexpected_req", dataAddr, 32'hFFFF_FFFF);
        end else begin
          monReq = reqQ.pop_front();
          chk("req_addr", dataAddr, monReq.addr);
          chk("req_size", 32'(dataSize), 32'(monReq.size));
          chk("req_wr", 32'(dataWr), 32'(monReq.wr));
          if (monReq.wr) chk("req_wdata", dataWdata, monReq.wdata);
          curIsLoad = !monReq.wr;
        end
      end
      if (dataDataOk) begin
        chk("dstall_at_data_ok", 32'(dStall), 32'h0);
        if (curIsLoad) begin
          if (loadQ.size() == 0) chk("unexpected_load", readdataM, 32'hFFFF_FFFF);
          else chk("load_data", readdataM, loadQ.pop_front());
        end
      end
    end
  end

  task automatic holdChk();
    chk("hold_dstall", 32'(dStall), 32'h0);
    chk("hold_req", 32'(dataReq), 32'h0);
    chk("hold_rdata", readdataM, lastLoad);
  endtask

  task automatic doTxn(input bit isWr, input logic [31:0] va, input logic [3:0] sel,
                       input logic [31:0] wd, input int aWait, input int dWait,
                       input int hold, input bit flushInData);
    req_t        r;
    logic [31:0] pa = mapAddr(va);
    logic [31:0] w;
    bit          accepted = 1'b0;
    bit          doFlush = 1'b0;
    bit          done = 1'b0;
    r.addr = pa; r.size = expSize(sel); r.wr = isWr; r.wdata = wd;
    reqQ.push_back(r);
    if (isWr) begin
      w = memRead(pa, 1'b0);
      for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = wd[8*b +: 8];
      modelMem[pa >> 2] = w;
    end else begin
      lastLoad = memRead(pa, 1'b0);
      loadQ.push_back(lastLoad);
    end
    aWaitCfg = aWait;
    dWaitCfg = dWait;
    @(posedge clk);
    #1;
    memreadM = !isWr; memwriteM = isWr; aluoutM = va; selectM = sel;
    writedataM = wd; flushM = 1'b0; extStall = (hold > 0);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        flushM = doFlush;
      end
      @(negedge clk);
      if (dataDataOk) begin
        done = 1'b1;
        break;
      end
      if (!doFlush) chk("stall_wait", 32'(dStall), 32'h1);
      if (!accepted) chk("req_held", 32'(dataReq), 32'h1);
      if (dataReq && dataAddrOk) begin
        accepted = 1'b1;
        if (flushInData) doFlush = 1'b1;
      end
    end
    if (!done) chk("txn_timeout", 32'h0, 32'h1);
    for (int j = 0; j < hold; j++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      holdChk();
    end
    if (hold > 0) begin
      @(posedge clk);
      #1;
      extStall = 1'b0;
      @(negedge clk);
      holdChk();
    end
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    memreadM = 1'b0; memwriteM = 1'b0; flushM = 1'b0; extStall = 1'b0;
    @(negedge clk);
    chk("idle_req", 32'(dataReq), 32'h0);
    chk("idle_dstall", 32'(dStall), 32'h0);
  endtask

  task automatic flushDrop();
    @(posedge clk);
    #1;
    memreadM = 1'b1; memwriteM = 1'b0; flushM = 1'b1; extStall = 1'b0;
    aluoutM = $urandom; selectM = 4'hF;
    @(negedge clk);
    chk("flush_req", 32'(dataReq), 32'h0);
    chk("flush_dstall", 32'(dStall), 32'h0);
  endtask

  task automatic resetInData();
    req_t r;
    r.addr = mapAddr(32'h8000_0100); r.size = 2'd2; r.wr = 1'b0; r.wdata = 32'h0;
    reqQ.push_back(r);
    aWaitCfg = 0;
    dWaitCfg = 5;
    @(posedge clk);
    #1;
    memreadM = 1'b1; memwriteM = 1'b0; flushM = 1'b0; extStall = 1'b0;
    aluoutM = 32'h8000_0100; selectM = 4'hF; writedataM = 32'h0;
    @(negedge clk);
    chk("rst_pre_stall", 32'(dStall), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    memreadM = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    lastLoad = 32'h0;
    chk("rst_mid_req", 32'(dataReq), 32'h0);
    chk("rst_mid_dstall", 32'(dStall), 32'h0);
    chk("rst_mid_rdata", readdataM, 32'h0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b0;
    memreadM = 1'b0; memwriteM = 1'b0; flushM = 1'b0; extStall = 1'b0;
    aluoutM = '0; writedataM = '0; selectM = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req", 32'(dataReq), 32'h0);
    chk("reset_dstall", 32'(dStall), 32'h0);
    chk("reset_rdata", readdataM, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    doTxn(1'b1, 32'h8000_0010, 4'hF, 32'hDEADBEEF, 0, 0, 0, 1'b0);
    doTxn(1'b0, 32'h8000_0010, 4'hF, 32'h1234_5678, 0, 1, 0, 1'b0);
    doTxn(1'b1, 32'h0000_0022, 4'b0100, 32'h00AB_0000, 3, 0, 0, 1'b0);
    doTxn(1'b0, 32'h0000_0020, 4'hF, 32'h0, 1, 0, 2, 1'b0);
    doTxn(1'b1, 32'hC000_0040, 4'h3, 32'h0000_5A5A, 0, 0, 2, 1'b0);
    flushDrop();
    idleCycle();
    doTxn(1'b0, 32'h8000_0010, 4'hF, 32'h0, 0, 2, 0, 1'b1);
    doTxn(1'b1, 32'hA000_0044, 4'hC, 32'h7777_0000, 1, 1, 1, 1'b1);
    resetInData();

    for (int i = 0; i < 150; i++) begin
      int          kind = int'($urandom_range(0, 9));
      logic [3:0]  sel = selTab[$urandom_range(0, 6)];
      logic [31:0] va = regionTab[$urandom_range(0, 3)]
                        | (32'($urandom_range(0, 15)) << 2) | 32'(laneOf(sel));
      int          hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (kind == 0) idleCycle();
      else if (kind == 1) flushDrop();
      else doTxn(1'($urandom_range(0, 1)), va, sel, $urandom, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), hold, ($urandom_range(0, 9) == 0));
    end

    idleCycle();
    chk("queues_empty", 32'(reqQ.size() + loadQ.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/d_sram_bridge.md
# d_sram_bridge

Data-side bridge between the MIPS core's memory stage and a SRAM-like slave port. It turns the core's single-cycle data access (memreadM/memwriteM, aluoutM, writedataM, selectM, readdataM) into a req/addr_ok/data_ok handshake. It raises a stall request until the transaction completes and holds the load data while the rest of the pipeline is still stalled. It sits between mips and the SRAM-like-to-AXI converter.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge)
- memreadM  in  1  load in M stage
- memwriteM  in  1  store in M stage
- aluoutM  in  AW  byte address
- writedataM  in  DW  store data, already lane-aligned
- selectM  in  4  byte enables
- flushM  in  1  exception/flush of the M-stage instruction
- longest_stall  in  1  OR of all pipeline stall sources, including d_stall
- readdataM  out  DW  load data to the core
- d_stall  out  1  stall request from this bridge
- data_req  out  1  request valid
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  AW  request address
- data_wdata  out  DW  write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid or write done
- data_rdata  in  DW  read data

## Operation
- access = (memreadM | memwriteM) & ~flushM.
- States:
  - S_IDLE: no transaction in flight.
  - S_DATA: request accepted, waiting for data_ok.
  - S_DONE: transaction complete, pipeline still stalled by another source.
- S_IDLE:
  - data_req = access.
  - data_addr_ok & access → S_DATA.
  - Otherwise stay.
- S_DATA:
  - data_req = 0.
  - data_data_ok & longest_stall → S_DONE.
  - data_data_ok & ~longest_stall → S_IDLE.
- S_DONE:
  - data_req = 0.
  - ~longest_stall → S_IDLE.
- data_wr = memwriteM. data_wdata = writedataM. data_addr = mapped aluoutM.
- data_size is decoded from selectM:
  - 4'b1111 → 2.
  - 4'b0011 or 4'b1100 → 1.
  - Any one-hot value → 0.
  - All other values → 2. This case is illegal and is flagged by an assertion.
- rdata_r captures data_rdata on data_data_ok in S_DATA, for loads only.
- readdataM = (state==S_DATA & data_data_ok) ? data_rdata : rdata_r.
- d_stall = access & ~(state==S_DATA & data_data_ok) & (state!=S_DONE).
- Flush:
  - flushM with state==S_IDLE drops the request before it is accepted.
  - flushM in S_DATA or S_DONE is ignored. An accepted transaction always runs to data_ok.

## Timing
- Reset values:
  - state = S_IDLE.
  - rdata_r = 0.
  - Outputs: data_req = 0, d_stall = 0, readdataM = 0.
- readdataM, d_stall and data_req are combinational from state and inputs. No added cycle exists when the slave answers immediately.
- Minimum latency: addr_ok in cycle N and data_ok in cycle N+1 give d_stall=1 in cycle N and d_stall=0 in cycle N+1.
- addr_ok and data_ok in the same cycle from S_IDLE is illegal and is asserted against. Data_ok is accepted only in S_DATA.
- Only one outstanding transaction at any time.
- Reset mid-transaction returns the bridge to S_IDLE. The slave is reset in the same cycle by the same rst.
- rdata_r holds its value through S_DONE until the pipeline advances.

## Configuration
- DBRIDGE_ADDR_MAP_EN defined:
  - aluoutM in 0x8000_0000–0xBFFF_FFFF (kseg0/kseg1) drives data_addr = {3'b000, aluoutM[28:0]}.
  - All other addresses pass through unchanged.
- DBRIDGE_ADDR_MAP_EN undefined: data_addr = aluoutM.

## Structure
- Shared package holds:
  - State enum: S_IDLE, S_DATA, S_DONE.
  - Size constants: SIZE_B=0, SIZE_H=1, SIZE_W=2.
  - The address-map constants.
- One sub-module: d_addr_map, holding the macro-gated virtual-to-physical mapping. The FSM stays in d_sram_bridge.

## Test plan
- Word load at 0x8000_0010, selectM=1111, addr_ok in cycle 0, data_ok in cycle 2 with rdata=0xDEADBEEF:
  - data_size=2.
  - data_addr=0x0000_0010 with DBRIDGE_ADDR_MAP_EN, otherwise 0x8000_0010.
  - d_stall high for cycles 0–1.
  - readdataM=0xDEADBEEF in cycle 2.
- Byte store, selectM=0100, addr_ok held low 3 cycles:
  - data_req stays high with stable addr, wdata and size=0.
  - d_stall stays high until data_ok.
- Load completes while longest_stall is held 2 more cycles:
  - Bridge sits in S_DONE.
  - readdataM holds the captured value.
  - d_stall=0.
  - No second data_req is issued.
- flushM asserted with memreadM while addr_ok=0: data_req=0, d_stall=0, state stays S_IDLE.
- flushM asserted in S_DATA: the transaction completes on data_ok and the bridge returns to S_IDLE.
- rst=0 in S_DATA: next cycle state=S_IDLE, data_req=0, readdataM=0.
